// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared widths, requester indices and request type for the regfile write arbiter
package rf_arb_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  localparam logic REQ_WBU = 1'b0;
  localparam logic REQ_MDU = 1'b1;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] waddr;
    logic [RF_DATA_W-1:0] wdata;
  } rf_wr_req_t;

endpackage

// File: rtl/rf_arb_grant.sv
// rtl/rf_arb_grant.sv - combinational one-hot grant for the two regfile write requesters
// RF_WR_ARBITER_RR_EN selects round-robin on contention; otherwise requester 0 has fixed priority.
module rf_arb_grant
  import rf_arb_pkg::*;
(
  input  logic       i_req0_valid,
  input  logic       i_req1_valid,
  input  logic       i_last_gnt,
  output logic [1:0] o_gnt
);

`ifndef RF_WR_ARBITER_RR_EN
  logic unused_last_gnt;
  assign unused_last_gnt = i_last_gnt;
`endif

  always_comb begin
    o_gnt = 2'b00;
    if (i_req0_valid && i_req1_valid) begin
`ifdef RF_WR_ARBITER_RR_EN
      // Contention goes to whoever did not fire last.
      if (i_last_gnt == REQ_MDU) o_gnt[REQ_WBU] = 1'b1;
      else                       o_gnt[REQ_MDU] = 1'b1;
`else
      o_gnt[REQ_WBU] = 1'b1;
`endif
    end else if (i_req0_valid) begin
      o_gnt[REQ_WBU] = 1'b1;
    end else if (i_req1_valid) begin
      o_gnt[REQ_MDU] = 1'b1;
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// rtl/rf_wr_arbiter.sv - arbitrates the integer regfile write port between write-back and mul/div
// Arbitration policy is chosen by RF_WR_ARBITER_RR_EN inside rf_arb_grant.
module rf_wr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [ADDR_W-1:0] i_req0_waddr,
  input  logic [DATA_W-1:0] i_req0_wdata,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [ADDR_W-1:0] i_req1_waddr,
  input  logic [DATA_W-1:0] i_req1_wdata,
  output logic              o_reg_wena,
  output logic [ADDR_W-1:0] o_reg_waddr,
  output logic [DATA_W-1:0] o_reg_wdata,
  output logic              o_req0_done,
  output logic              o_req1_done
);

  logic [1:0]        gnt;
  logic              fire0, fire1;
  logic [ADDR_W-1:0] sel_waddr;
  logic [DATA_W-1:0] sel_wdata;

  logic              last_gnt_q, last_gnt_d;
  logic              reg_wena_q, reg_wena_d;
  logic [ADDR_W-1:0] reg_waddr_q, reg_waddr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              req0_done_q, req0_done_d;
  logic              req1_done_q, req1_done_d;

  rf_arb_grant u_grant (
    .i_req0_valid (i_req0_valid),
    .i_req1_valid (i_req1_valid),
    .i_last_gnt   (last_gnt_q),
    .o_gnt        (gnt)
  );

  assign o_req0_ready = gnt[REQ_WBU];
  assign o_req1_ready = gnt[REQ_MDU];
  assign fire0        = i_req0_valid & o_req0_ready;
  assign fire1        = i_req1_valid & o_req1_ready;

  assign sel_waddr = fire1 ? i_req1_waddr : i_req0_waddr;
  assign sel_wdata = fire1 ? i_req1_wdata : i_req0_wdata;

  always_comb begin
    last_gnt_d  = last_gnt_q;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wena_d  = 1'b0;
    req0_done_d = 1'b0;
    req1_done_d = 1'b0;
    if (fire0 || fire1) begin
      last_gnt_d  = fire1 ? REQ_MDU : REQ_WBU;
      reg_waddr_d = sel_waddr;
      reg_wdata_d = sel_wdata;
      // x0 is hardwired zero: retire the request but suppress the write.
      reg_wena_d  = (sel_waddr != '0);
      req0_done_d = fire0;
      req1_done_d = fire1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_gnt_q  <= REQ_MDU;
      reg_wena_q  <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      req0_done_q <= 1'b0;
      req1_done_q <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      reg_wena_q  <= reg_wena_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      req0_done_q <= req0_done_d;
      req1_done_q <= req1_done_d;
    end
  end

  assign o_reg_wena  = reg_wena_q;
  assign o_reg_waddr = reg_waddr_q;
  assign o_reg_wdata = reg_wdata_q;
  assign o_req0_done = req0_done_q;
  assign o_req1_done = req1_done_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb/tb_rf_wr_arbiter.sv - scoreboard bench for rf_wr_arbiter (expectations follow RF_WR_ARBITER_RR_EN)
module tb_rf_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_waddr, req1_waddr;
  logic [31:0] req0_wdata, req1_wdata;
  logic        reg_wena;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        req0_done, req1_done;

  typedef struct {
    logic        wena;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        d0;
    logic        d1;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;
  bit   mon_en = 1'b1;

  rf_wr_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0_valid (req0_valid),
    .o_req0_ready (req0_ready),
    .i_req0_waddr (req0_waddr),
    .i_req0_wdata (req0_wdata),
    .i_req1_valid (req1_valid),
    .o_req1_ready (req1_ready),
    .i_req1_waddr (req1_waddr),
    .i_req1_wdata (req1_wdata),
    .o_reg_wena   (reg_wena),
    .o_reg_waddr  (reg_waddr),
    .o_reg_wdata  (reg_wdata),
    .o_req0_done  (req0_done),
    .o_req1_done  (req1_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
  endtask

  // Monitor: any done pulse must match the oldest expected retirement.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (req0_done || req1_done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", {30'd0, req1_done, req0_done}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("wena",  {31'd0, reg_wena},  {31'd0, e.wena});
            chk("waddr", {27'd0, reg_waddr}, {27'd0, e.waddr});
            chk("wdata", reg_wdata,          e.wdata);
            chk("done0", {31'd0, req0_done}, {31'd0, e.d0});
            chk("done1", {31'd0, req1_done}, {31'd0, e.d1});
          end
        end else begin
          chk("idle_wena", {31'd0, reg_wena}, 32'd0);
        end
      end
    end
  end

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    req0_valid = v0; req0_waddr = a0; req0_wdata = d0;
    req1_valid = v1; req1_waddr = a1; req1_wdata = d1;
  endtask

  // One cycle of stimulus; er0/er1 are the hand-computed readies.
  task automatic step(input string name,
                      input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic er0, input logic er1);
    @(negedge clk);
    drive(v0, a0, d0, v1, a1, d1);
    #1;
    chk({name, "_ready0"}, {31'd0, req0_ready}, {31'd0, er0});
    chk({name, "_ready1"}, {31'd0, req1_ready}, {31'd0, er1});
    if (er0) exp_q.push_back('{(a0 != 5'd0), a0, d0, 1'b1, 1'b0});
    if (er1) exp_q.push_back('{(a1 != 5'd0), a1, d1, 1'b0, 1'b1});
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_wena",  {31'd0, reg_wena},   32'd0);
    chk("rst_waddr", {27'd0, reg_waddr},  32'd0);
    chk("rst_wdata", reg_wdata,           32'd0);
    chk("rst_done0", {31'd0, req0_done},  32'd0);
    chk("rst_done1", {31'd0, req1_done},  32'd0);
    chk("rst_rdy",   {30'd0, req1_ready, req0_ready}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    step("single", 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 1, 0);
    step("idle0",  0, 0, 0, 0, 0, 0, 0, 0);
    step("idle1",  0, 0, 0, 0, 0, 0, 0, 0);

    do_reset();
`ifdef RF_WR_ARBITER_RR_EN
    step("cont0", 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 0);
    step("cont1", 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 1);
    step("cont2", 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 0);
    step("cont3", 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 1);
`else
    step("cont0", 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 0);
    step("cont1", 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 0);
    step("cont2", 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 0);
    step("cont3", 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 0);
`endif
    step("drop0",  0, 0, 0, 1, 5'd2, 32'h22, 0, 1);
    step("idle2",  0, 0, 0, 0, 0, 0, 0, 0);

    step("x0",     0, 0, 0, 1, 5'd0, 32'h1234, 0, 1);
    step("idle3",  0, 0, 0, 0, 0, 0, 0, 0);

    // Request fires in the same cycle reset asserts: nothing must retire.
    @(negedge clk);
    drive(1, 5'd7, 32'hCAFE0007, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready0", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    chk("midrst_wena",  {31'd0, reg_wena},  32'd0);
    chk("midrst_done0", {31'd0, req0_done}, 32'd0);
    rst_n = 1'b1;
    step("idle4",  0, 0, 0, 0, 0, 0, 0, 0);
    step("postrst", 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 1, 0);
    step("idle5",  0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    mon_en = 1'b0;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
# rf_wr_arbiter

Arbitrates the single integer-regfile write port between two requesters: requester 0 is the write-back unit, requester 1 is the long-latency multiply/divide unit. Each request is accepted through a valid/ready handshake and registered. The write reaches the regfile exactly one cycle later, and a per-requester done pulse is returned. The block sits between the producing units and the regfile, replacing the direct write-back → regfile connection.

## Interface
Parameters:
- DATA_W, 32, regfile data width
- ADDR_W, 5, regfile address width

Ports:
- i_clk  input  1  core clock; all state updates on rising edge
- i_rst_n  input  1  reset; asynchronous, active-low
- i_req0_valid  input  1  write-back unit has a write pending
- o_req0_ready  output  1  write-back write accepted this cycle
- i_req0_waddr  input  ADDR_W  write-back destination register
- i_req0_wdata  input  DATA_W  write-back data
- i_req1_valid  input  1  mul/div unit has a write pending
- o_req1_ready  output  1  mul/div write accepted this cycle
- i_req1_waddr  input  ADDR_W  mul/div destination register
- i_req1_wdata  input  DATA_W  mul/div data
- o_reg_wena  output  1  regfile write enable (registered)
- o_reg_waddr  output  ADDR_W  regfile write address (registered)
- o_reg_wdata  output  DATA_W  regfile write data (registered)
- o_req0_done  output  1  one-cycle pulse: requester-0 write retired
- o_req1_done  output  1  one-cycle pulse: requester-1 write retired

## Operation
- Handshakes and grant:
  - fire_N = i_reqN_valid & o_reqN_ready.
  - At most one fire per cycle.
  - ready is combinational from the two valids and the grant pointer. It is never asserted without the matching valid.
  - A requester holds valid, waddr and wdata stable until it sees ready. Dropping valid before ready is not allowed.
  - Single valid: that requester is granted immediately.
  - Both valid: resolved by the arbitration policy (see Configuration).
- Grant pointer (last_gnt, 1 bit):
  - Records the index of the most recent fire.
  - Updates on every fire.
  - Holds when nothing fires.
  - Reset value: 1, so requester 0 wins the first contention.
- Output register, on any fire:
  - o_reg_waddr and o_reg_wdata load the granted requester's fields.
  - o_reg_wena loads (waddr != 0).
  - o_reqN_done loads 1 for the granted N and 0 for the other.
- Output register, with no fire: o_reg_wena and both done pulses load 0. o_reg_waddr and o_reg_wdata hold their previous values.
- x0 destination:
  - The request is accepted normally and its done pulse is issued.
  - No regfile write occurs (o_reg_wena = 0).
- Reset values: o_reg_wena = 0, o_reg_waddr = 0, o_reg_wdata = 0, both done = 0, last_gnt = 1.
- Reset mid-operation: a request accepted in the cycle reset asserts is discarded. No write and no done pulse follow it.

## Timing
- Latency: fire in cycle T → o_reg_wena/waddr/wdata and o_reqN_done are valid in cycle T+1, for exactly one cycle.
- Throughput: one write per cycle. Back-to-back fires from the same or alternating requesters produce consecutive write cycles with no bubble.
- Loser of a contention sees ready = 0. It is granted no later than the next cycle in round-robin mode.
- No combinational path from any i_req*_ field to the o_reg_* outputs. Only the ready outputs are combinational.

## Configuration
- Macro: RF_WR_ARBITER_RR_EN.
- Defined: round-robin. On contention, grant !last_gnt, so requesters strictly alternate while both stay valid.
- Undefined: fixed priority. Requester 0 always wins contention. last_gnt is still maintained but ignored, and requester 1 can starve while requester 0 stays valid.

## Structure
- Shared package rf_arb_pkg holds:
  - DATA_W and ADDR_W defaults.
  - Requester index constants REQ_WBU = 0 and REQ_MDU = 1.
  - Typedef rf_wr_req_t {valid, waddr, wdata}.
- Sub-module rf_arb_grant: purely combinational grant selection. Inputs are the two valids and last_gnt; outputs are a one-hot grant. It is the only place that tests RF_WR_ARBITER_RR_EN.
- Top level holds last_gnt, the output register and the data mux.

## Test plan
- Reset check: hold i_rst_n = 0 → all outputs 0. After release, with no valids, o_reg_wena stays 0.
- Single requester: req0 valid, waddr = 5, wdata = 0xDEADBEEF at T → o_req0_ready = 1 at T. At T+1: o_reg_wena = 1, waddr = 5, wdata = 0xDEADBEEF, o_req0_done = 1. At T+2: o_reg_wena = 0.
- Contention, RR defined: both valid for 4 cycles from reset (req0 → x1 with 0x11, req1 → x2 with 0x22) → grants alternate 0, 1, 0, 1. Writes appear on consecutive cycles with matching done pulses.
- Contention, RR undefined: same stimulus → req0 granted every cycle. o_req1_ready stays 0 until req0 drops valid, then req1 is granted that cycle.
- x0 drop: req1 waddr = 0, wdata = 0x1234 → ready = 1. At T+1: o_req1_done = 1 and o_reg_wena = 0.
- Reset mid-flight: assert i_rst_n = 0 in the same cycle as a req0 fire → no write and no done afterwards. The first contention after release grants req0.
